// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART receiver: FSM encoding,
// oversampling constants, divisor computation and the 2-of-3 vote.
package uart_pkg;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned SI_W       = 4;

    localparam logic [SI_W-1:0] SI_VOTE_A = 4'd7;
    localparam logic [SI_W-1:0] SI_VOTE_B = 4'd8;
    localparam logic [SI_W-1:0] SI_VOTE_C = 4'd9;
    localparam logic [SI_W-1:0] SI_LAST   = 4'd15;

    typedef enum logic [2:0] {
        ST_WAIT_IDLE = 3'd0,
        ST_IDLE      = 3'd1,
        ST_START     = 3'd2,
        ST_DATA      = 3'd3,
        ST_STOP      = 3'd4
    } rx_state_e;

    // Rounded clocks per oversample tick.
    function automatic int unsigned calc_div(input int unsigned clk_freq,
                                             input int unsigned baud);
        return (clk_freq + baud * 8) / (baud * OVERSAMPLE);
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous FIFO with registered full/empty flags; simultaneous push and
// pop are both honoured, including when full.
module uart_byte_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             full_q;
    logic             empty_q;
    logic             do_push_c;
    logic             do_pop_c;

    always_comb begin
        do_pop_c  = pop_i & ~empty_q;
        do_push_c = push_i & (~full_q | do_pop_c);
        count_d   = count_q + CW'(do_push_c) - CW'(do_pop_c);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push_c) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop_c) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
            full_q  <= (count_d == CNT_FULL);
            empty_q <= (count_d == '0);
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/uart_rx_fifo_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, 16x oversampling prescaler,
// 2-of-3 mid-bit vote, framing/overrun detection and a small output FIFO.
module uart_rx_fifo_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD);
    localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

    rx_state_e       state_q, state_d;
    logic [1:0]      sync_q;
    logic [1:0]      prime_q;
    logic            rxs;
    logic            rxs_prev_q;
    logic [PW-1:0]   cnt_q, cnt_d;
    logic [SI_W-1:0] si_q, si_d;
    logic            s7_q, s7_d;
    logic            s8_q, s8_d;
    logic [3:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            frame_err_q, frame_err_d;
    logic            overrun_q, overrun_d;
    logic            busy_q, busy_d;
    logic            tick_c;
    logic            vote_c;
    logic            vote_tick_c;
    logic            push_c;
    logic            pop_c;
    logic            full_c;
    logic            empty_c;

    assign rxs = sync_q[1];

    // prime_q keeps WAIT_IDLE from trusting the synchronizer's reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= 2'b11;
            prime_q    <= 2'b00;
            rxs_prev_q <= 1'b1;
        end else begin
            sync_q     <= {sync_q[0], rxd};
            prime_q    <= {prime_q[0], 1'b1};
            rxs_prev_q <= rxs;
        end
    end

    always_comb begin
        tick_c      = (cnt_q == PRE_LAST);
        vote_c      = majority3(s7_q, s8_q, rxs);
        vote_tick_c = tick_c && (si_q == SI_VOTE_C);
        pop_c       = ~empty_c & rx_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_WAIT_IDLE;
            cnt_q       <= '0;
            si_q        <= '0;
            s7_q        <= 1'b1;
            s8_q        <= 1'b1;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            si_q        <= si_d;
            s7_q        <= s7_d;
            s8_q        <= s8_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = tick_c ? '0 : cnt_q + PW'(1);
        si_d        = tick_c ? si_q + SI_W'(1) : si_q;
        s7_d        = (tick_c && si_q == SI_VOTE_A) ? rxs : s7_q;
        s8_d        = (tick_c && si_q == SI_VOTE_B) ? rxs : s8_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        push_c      = 1'b0;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        case (state_q)
            ST_WAIT_IDLE: begin
                if (prime_q[1] && rxs) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (rxs_prev_q && !rxs) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                    si_d    = '0;
                end
            end
            ST_START: begin
                if (vote_tick_c) begin
                    state_d   = vote_c ? ST_IDLE : ST_DATA;
                    bit_idx_d = '0;
                end
            end
            ST_DATA: begin
                if (vote_tick_c) begin
                    shift_d[bit_idx_q[2:0]] = vote_c;
                    bit_idx_d               = bit_idx_q + 4'd1;
                end
                // Leave once the eighth bit's window has fully elapsed.
                if (tick_c && si_q == SI_LAST && bit_idx_q == 4'd8) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (vote_tick_c) begin
                    if (vote_c) begin
                        if (full_c && !pop_c) begin
                            overrun_d = 1'b1;
                        end else begin
                            push_c = 1'b1;
                        end
                        state_d = ST_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_WAIT_IDLE;
                    end
                end
            end
            default: state_d = ST_WAIT_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    uart_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_c),
        .wdata_i (shift_q),
        .pop_i   (pop_c),
        .rdata_o (rx_data),
        .full_o  (full_c),
        .empty_o (empty_c)
    );

    assign rx_valid  = ~empty_c;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_fifo_rx.sv
// Directed and randomized checks of uart_rx_fifo_rx at default parameters
// against a byte-level reference model of the serial line and FIFO.
module tb_uart_rx_fifo_rx;

    localparam int unsigned BIT_CLKS = 432;
    localparam int unsigned DEPTH    = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rxd;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int unsigned n_vec    = 0;
    int unsigned n_err    = 0;
    int unsigned fe_cnt   = 0;
    int unsigned ov_cnt   = 0;
    int unsigned both_cnt = 0;
    logic [7:0]  got_q[$];
    logic [7:0]  exp_q[$];

    always #5 clk = ~clk;

    uart_rx_fifo_rx dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rxd       (rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    // Observe handshakes and pulses midway between active edges.
    always @(negedge clk) begin
        if (rx_valid === 1'b1 && rx_ready === 1'b1) got_q.push_back(rx_data);
        if (frame_err === 1'b1) fe_cnt++;
        if (overrun === 1'b1) ov_cnt++;
        if (frame_err === 1'b1 && overrun === 1'b1) both_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic clks(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v, input bit glitch);
        rxd = v;
        if (!glitch) begin
            clks(BIT_CLKS);
        end else begin
            clks(232);
            rxd = ~v;
            clks(20);
            rxd = v;
            clks(180);
        end
    endtask

    task automatic send_head(input logic [7:0] b, input int glitch_bit);
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i], i == glitch_bit);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v, input int glitch_bit);
        send_head(b, glitch_bit);
        drive_bit(stop_v, 1'b0);
        rxd = 1'b1;
    endtask

    task automatic drain();
        rx_ready = 1'b1;
        clks(2 * DEPTH + 4);
        rx_ready = 1'b0;
        clks(1);
    endtask

    task automatic check_queue(input string tag);
        chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int unsigned fe0;
        int unsigned ov0;
        int unsigned n_burst;
        logic [7:0]  b;

        rst_n    = 1'b0;
        rxd      = 1'b1;
        rx_ready = 1'b0;
        clks(5);
        chk("rst_rx_data", 32'(rx_data), 32'h0);
        chk("rst_rx_valid", 32'(rx_valid), 32'h0);
        chk("rst_frame_err", 32'(frame_err), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);
        chk("rst_busy", 32'(busy), 32'h1);
        rst_n = 1'b1;
        clks(5);
        chk("armed_busy", 32'(busy), 32'h0);

        // Clean 0x55, observe busy falling mid-stop.
        send_head(8'h55, -1);
        rxd = 1'b1;
        clks(200);
        chk("f55_busy_early_stop", 32'(busy), 32'h1);
        clks(100);
        chk("f55_busy_mid_stop", 32'(busy), 32'h0);
        chk("f55_valid", 32'(rx_valid), 32'h1);
        chk("f55_data", 32'(rx_data), 32'h55);
        clks(BIT_CLKS - 300);
        chk("f55_no_ferr", 32'(fe_cnt), 32'h0);
        exp_q.push_back(8'h55);
        drain();
        chk("f55_drained", 32'(rx_valid), 32'h0);
        check_queue("f55");

        // Short low glitch is a false start.
        rxd = 1'b0;
        clks(135);
        rxd = 1'b1;
        clks(BIT_CLKS - 135);
        chk("glitch_busy", 32'(busy), 32'h0);
        chk("glitch_valid", 32'(rx_valid), 32'h0);
        chk("glitch_ferr", 32'(fe_cnt), 32'h0);
        chk("glitch_ovr", 32'(ov_cnt), 32'h0);

        // Framing error then recovery.
        send_frame(8'hA3, 1'b0, -1);
        clks(BIT_CLKS);
        chk("fa3_ferr", 32'(fe_cnt), 32'h1);
        chk("fa3_valid", 32'(rx_valid), 32'h0);
        chk("fa3_busy", 32'(busy), 32'h0);
        send_frame(8'h3C, 1'b1, -1);
        chk("f3c_valid", 32'(rx_valid), 32'h1);
        chk("f3c_data", 32'(rx_data), 32'h3C);
        exp_q.push_back(8'h3C);
        drain();
        check_queue("f3c");

        // Five back-to-back frames into a four-deep FIFO.
        ov0 = ov_cnt;
        for (int k = 1; k <= 5; k++) begin
            send_frame(8'(k), 1'b1, -1);
            if (k <= int'(DEPTH)) exp_q.push_back(8'(k));
        end
        chk("ovr_pulses", 32'(ov_cnt - ov0), 32'h1);
        drain();
        chk("ovr_drained", 32'(rx_valid), 32'h0);
        check_queue("ovr");

        // One corrupted oversample inside data bit 3.
        send_frame(8'h0F, 1'b1, 3);
        exp_q.push_back(8'h0F);
        drain();
        check_queue("vote");

        // Reset during bit 4 with a byte already buffered.
        b = 8'($urandom);
        send_frame(b, 1'b1, -1);
        chk("pre_rst_valid", 32'(rx_valid), 32'h1);
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        b = 8'hC6;
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(b[i], 1'b0);
        rxd = b[4];
        clks(200);
        rst_n = 1'b0;
        rxd   = 1'b0;
        clks(5);
        rst_n = 1'b1;
        clks(2 * BIT_CLKS);
        chk("rst_mid_valid", 32'(rx_valid), 32'h0);
        chk("rst_mid_data", 32'(rx_data), 32'h0);
        chk("rst_mid_busy", 32'(busy), 32'h1);
        chk("rst_mid_pulses", 32'((fe_cnt - fe0) + (ov_cnt - ov0)), 32'h0);
        rxd = 1'b1;
        clks(BIT_CLKS);
        chk("rst_rearm_busy", 32'(busy), 32'h0);
        send_frame(8'hC6, 1'b1, -1);
        exp_q.push_back(8'hC6);
        drain();
        check_queue("rst_c6");

        // Random burst with random gaps: first DEPTH stored, rest overrun.
        n_burst = $urandom_range(2, 5);
        ov0 = ov_cnt;
        for (int k = 0; k < int'(n_burst); k++) begin
            b = 8'($urandom);
            clks($urandom_range(0, 150));
            send_frame(b, 1'b1, -1);
            if (k < int'(DEPTH)) exp_q.push_back(b);
        end
        chk("rand_ovr", 32'(ov_cnt - ov0),
            (n_burst > DEPTH) ? 32'(n_burst - DEPTH) : 32'h0);
        drain();
        check_queue("rand");

        chk("never_both_pulses", 32'(both_cnt), 32'h0);
        chk("total_ferr", 32'(fe_cnt), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
